// File: rtl/serializer.sv
// Byte-to-serial transmitter: shifts a byte out MSB-first on data_out, strobing each
// bit with a write_out pulse of PULSE_CYCLES high followed by GAP_CYCLES low.
module serializer #(
    parameter int unsigned PULSE_CYCLES = 10,
    parameter int unsigned GAP_CYCLES   = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic       status_in,
    output logic       data_out,
    output logic       write_out,
    output logic       done_out
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SETUP = 3'd2,
        S_HIGH  = 3'd3,
        S_LOW   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              data_q, data_d;
    logic              write_q, write_d;
    logic              done_q, done_d;

    // State, datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            data_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            write_q <= write_d;
            done_q  <= done_d;
        end
    end

    // Next state plus shift register, bit counter and phase timer
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    shift_d = byte_in;
                    bit_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (status_in) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_HIGH;
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    shift_d = {shift_q[BYTE_W-2:0], 1'b0};
                    bit_d   = bit_q + BIT_W'(1);
                    state_d = (bit_d == BIT_W'(BYTE_W)) ? S_IDLE : S_SETUP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Phase timer reloads on every state entry so it never wraps
        if (state_d != state_q) begin
            case (state_d)
                S_HIGH:  cnt_d = CNT_W'(PULSE_CYCLES - 1);
                S_LOW:   cnt_d = CNT_W'(GAP_CYCLES - 1);
                default: cnt_d = '0;
            endcase
        end
    end

    // Output values registered from the upcoming state so they align with it
    always_comb begin
        ready_d = (state_d == S_IDLE);
        write_d = (state_d == S_HIGH);
        data_d  = data_q;
        done_d  = (state_q == S_LOW) && (state_d == S_IDLE);
        if (state_d == S_SETUP) begin
            data_d = shift_d[BYTE_W-1];
        end
    end

    assign ready_out = ready_q;
    assign data_out  = data_q;
    assign write_out = write_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: cycle-offset reference model plus a byte decoder on write_out.
module tb_serializer;

    localparam int P = 10;
    localparam int G = 10;
    localparam int B = 1 + P + G;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byt   = 8'h00;
    logic       vld   = 1'b0;
    logic       st    = 1'b0;
    logic       ready_out, data_out, write_out, done_out;

    int total = 0;
    int bad   = 0;

    // reference model: mode 0 idle, 1 waiting for status, 2 sending (offset from first SETUP edge)
    int         m_mode = 0;
    int         m_off  = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_acc  = 1'b0;
    logic       e_ready = 1'b1, e_data = 1'b0, e_write = 1'b0, e_done = 1'b0;
    logic [7:0] expq[$];

    // decoder of the serial stream
    logic       mon_prev = 1'b0;
    logic [7:0] mon_bits = 8'h00;
    int         mon_n    = 0;

    serializer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clock     (clock),
        .reset     (reset),
        .byte_in   (byt),
        .valid_in  (vld),
        .ready_out (ready_out),
        .status_in (st),
        .data_out  (data_out),
        .write_out (write_out),
        .done_out  (done_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] sh;
        m_acc  = 1'b0;
        e_done = 1'b0;
        if (reset) begin
            m_mode  = 0;
            e_ready = 1'b1;
            e_data  = 1'b0;
            e_write = 1'b0;
        end else begin
            case (m_mode)
                0: if (vld) begin
                    m_mode  = 1;
                    m_byte  = byt;
                    e_ready = 1'b0;
                    m_acc   = 1'b1;
                    expq.push_back(byt);
                end
                1: if (st) begin
                    m_mode = 2;
                    m_off  = 0;
                    e_data = m_byte[7];
                end
                default: begin
                    m_off++;
                    if (m_off == 8 * B) begin
                        m_mode  = 0;
                        e_ready = 1'b1;
                        e_done  = 1'b1;
                        e_write = 1'b0;
                    end else begin
                        e_write = ((m_off % B) >= 1) && ((m_off % B) <= P);
                        sh      = m_byte << (m_off / B);
                        e_data  = sh[7];
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        chk("ready", 32'(ready_out), 32'(e_ready));
        chk("data",  32'(data_out),  32'(e_data));
        chk("write", 32'(write_out), 32'(e_write));
        chk("done",  32'(done_out),  32'(e_done));
        if (write_out && !mon_prev) begin
            mon_bits = {mon_bits[6:0], data_out};
            mon_n++;
        end
        mon_prev = write_out;
        if (done_out) begin
            chk("qdepth", 32'(expq.size()), 32'd1);
            if (expq.size() > 0) chk("byte", 32'(mon_bits), 32'(expq.pop_front()));
            chk("pulses", 32'(mon_n), 32'd8);
            mon_bits = 8'h00;
            mon_n    = 0;
        end
    endtask

    task automatic async_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_write", 32'(write_out), 32'd0);
        chk("rst_data",  32'(data_out),  32'd0);
        chk("rst_done",  32'(done_out),  32'd0);
        m_mode = 0; e_ready = 1'b1; e_data = 1'b0; e_write = 1'b0; e_done = 1'b0;
        expq.delete();
        mon_prev = 1'b0; mon_bits = 8'h00; mon_n = 0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(ready_out), 32'd1);
    endtask

    task automatic run_idle();
        for (int i = 0; i < 4000 && m_mode != 0; i++) tick();
        chk("idle_reached", 32'(m_mode), 32'd0);
    endtask

    task automatic accept(input logic [7:0] b);
        byt = b;
        vld = 1'b1;
        tick();
        chk("accepted", 32'(m_acc), 32'd1);
        vld = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(ready_out), 32'd1);

        // single 0x80 and its done latency
        st = 1'b1;
        accept(8'h80);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (done_out) break;
        end
        chk("done_lat", 32'(n), 32'd169);
        repeat (3) tick();

        // flow control: hold in WAIT for 50 cycles
        st = 1'b0;
        accept(8'hA5);
        repeat (50) tick();
        st = 1'b1;
        run_idle();
        repeat (2) tick();

        // busy ignore and status drop mid-byte
        accept(8'h81);
        repeat (30) tick();
        byt = 8'hFF; vld = 1'b1;
        tick();
        vld = 1'b0;
        for (int i = 0; i < 400 && m_off < 4 * B; i++) tick();
        st = 1'b0;
        run_idle();
        repeat (30) tick();
        st = 1'b1;

        // async reset during bit 4 HIGH, then a fresh byte
        accept(8'h0F);
        for (int i = 0; i < 400 && !(m_mode == 2 && m_off == 4 * B + 3); i++) tick();
        chk("mid_write", 32'(write_out), 32'd1);
        async_reset();
        accept(8'h3C);
        run_idle();
        repeat (2) tick();

        // back-to-back with valid held
        byt = 8'h80; vld = 1'b1; cnt = 0;
        for (int i = 0; i < 1000 && cnt < 4; i++) begin
            tick();
            if (m_acc) begin
                cnt++;
                byt = byt + 8'h01;
                if (cnt == 4) vld = 1'b0;
            end
        end
        chk("b2b_accepts", 32'(cnt), 32'd4);
        run_idle();

        // randomized traffic with one asynchronous reset
        for (int i = 0; i < 5000; i++) begin
            vld = ($urandom_range(0, 3) == 0);
            byt = 8'($urandom);
            st  = ($urandom_range(0, 4) != 0);
            if (i == 2500) async_reset();
            tick();
        end
        vld = 1'b0;
        st  = 1'b1;
        run_idle();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
